mioc_inv_od_array: RTL and testbench
====================================

Name: mioc_inv_od_array

Overview:
- N-channel open-drain inverter array, parametrised successor to the single-channel MIOC open-drain inverter.
- Each channel does three things:
  - synchronises and deglitches its input;
  - drives its pad low or releases it to Hi-Z, with selectable inverting or non-inverting polarity;
  - reads the pad back to flag external contention (line held low while the channel has released it).
- Sits between core logic and wired-AND open-drain pads. The pull-up is external to this block.

Parameters:
- NCH, 4: number of channels (>=1).
- FILT_CYC, 4: consecutive cycles a synchronised input must differ from the filtered value before the filtered value updates (>=1).
- FAULT_CYC, 8: consecutive cycles of contention required to set a fault (>=4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  NCH  raw logic inputs; asynchronous to clk.
- oe  input  NCH  per-channel output enable. 0 forces Hi-Z and disables fault monitoring.
- inv_mode  input  1  1 = invert (pad low when filtered input = 1); 0 = buffer (pad low when filtered input = 0). Quasi-static.
- z  output  NCH  open-drain pads: each bit is 1'b0 or 1'bz, never 1'b1.
- pad_in  input  NCH  pad readback; the resolved level of z after the external pull-up.
- pd  output  NCH  registered pull-down enables; z[i] = pd[i] ? 1'b0 : 1'bz.
- fault  output  NCH  sticky contention flags.
- fault_clr  input  NCH  per-channel synchronous clear pulse for fault.

Behaviour:
- Reset (async assert, any time, mid-operation included):
  - sync flops, filt, filter counters, fault counters, pd and fault all go to 0;
  - z is all Hi-Z.
  - Release is sampled on the next clk edge.
- Input synchroniser: two flops per channel, s1 <= in, s2 <= s1.
- Deglitch filter, per channel (counter width $clog2(FILT_CYC)+1):
  - s2 == filt: cnt <= 0.
  - s2 != filt and cnt == FILT_CYC-1: filt <= s2, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than FILT_CYC cycles at s2 never reaches filt.
  - Any return of s2 to filt restarts the count.
- Output stage:
  - pd[i] <= oe[i] & (inv_mode ? filt[i] : ~filt[i]).
  - z is combinational from pd.
- Latency: an input change first sampled at edge 1 sets s2 at edge 2, filt at edge 2+FILT_CYC and pd at edge 3+FILT_CYC. With defaults that is pd at edge 7.
- oe and inv_mode are not filtered. They affect pd on the next edge.
- Readback: pad_in passes through a 2-flop synchroniser to rb.
- Fault monitor, per channel (counter width $clog2(FAULT_CYC)+1):
  - Condition C = oe & ~pd & ~rb.
  - If fault_clr[i]: fcnt <= 0 and fault <= 0. Clear has priority over a set in the same cycle.
  - Else if C: fcnt increments, saturating at FAULT_CYC-1. fault <= 1 when C holds and fcnt == FAULT_CYC-1.
  - Else: fcnt <= 0.
- Fault behaviour:
  - fault stays sticky until cleared, independent of later C.
  - Fault never alters pd; it is report-only.
- Self-release transient: after the block itself releases pd, rb lags up to 3 cycles. FAULT_CYC >= 4 guarantees no false fault from this.
- Channels are fully independent. No cross-channel state.

Decomposition:
- No shared package needed. Localparams for counter widths stay inside the module.
- One natural sub-module: mioc_od_chan, a single channel containing the synchronisers, filter, output register and fault monitor. The top generates NCH instances and broadcasts clk, rst and inv_mode.

Test Plan:
1. Reset and hold: rst=1 mid-run with pd=4'b1111 -> pd, fault = 0 and z=4'bzzzz immediately (async); outputs stay 0 until inputs propagate after release.
2. Latency: defaults, inv_mode=1, oe=4'b0001, in[0] 0->1 sampled at edge 1 -> pd[0]=1 and z[0]=0 first at edge 7; z[3:1] stay z.
3. Glitch reject: in[1] high for 3 cycles -> pd[1] unchanged. High for 4 cycles -> filt[1] and pd[1] toggle, then toggle back after in returns low and stays low for 4 cycles.
4. Polarity: filt=0 on all channels, oe=4'b1111, inv_mode 1->0 -> pd 4'b0000 -> 4'b1111 one edge later.
5. Contention: oe[2]=1, pd[2]=0, pad_in[2] forced 0 -> fault[2]=1 after 8 cycles of C (10 edges after forcing, including 2 sync edges). Releasing pad_in keeps fault[2]=1. Pulsing fault_clr[2] clears it. Clear asserted in the set cycle -> fault[2] stays 0.
6. No false fault: toggle in[3] so pd[3] goes 1->0 with pad_in tracking z[3] through the pull-up model -> fault[3] never sets.

Source files
------------

// File: rtl/mioc_od_chan.sv
// Single open-drain inverter channel: input sync + deglitch, registered
// pull-down, and pad readback contention monitor with sticky fault.
module mioc_od_chan #(
  parameter int FILT_CYC  = 4,
  parameter int FAULT_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  input  logic oe_i,
  input  logic inv_mode_i,
  input  logic pad_in_i,
  input  logic fault_clr_i,
  output logic pd_o,
  output logic fault_o
);

  localparam int FCW = $clog2(FILT_CYC) + 1;
  localparam int KCW = $clog2(FAULT_CYC) + 1;
  localparam logic [FCW-1:0] FMAX = FCW'(FILT_CYC - 1);
  localparam logic [KCW-1:0] KMAX = KCW'(FAULT_CYC - 1);

  logic           s1_q, s2_q;
  logic           rb1_q, rb2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] cnt_q, cnt_d;
  logic           pd_q, pd_d;
  logic [KCW-1:0] fcnt_q, fcnt_d;
  logic           fault_q, fault_d;
  logic           cond;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (s2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == FMAX) begin
      filt_d = s2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign pd_d = oe_i & (inv_mode_i ? filt_q : ~filt_q);

  // Contention: we are not pulling down, yet the pad reads low.
  assign cond = oe_i & ~pd_q & ~rb2_q;

  always_comb begin
    fcnt_d  = fcnt_q;
    fault_d = fault_q;
    if (fault_clr_i) begin
      fcnt_d  = '0;
      fault_d = 1'b0;
    end else if (cond) begin
      if (fcnt_q == KMAX) fault_d = 1'b1;
      else fcnt_d = fcnt_q + 1'b1;
    end else begin
      fcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      rb1_q   <= 1'b0;
      rb2_q   <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
      pd_q    <= 1'b0;
      fcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      s1_q    <= in_i;
      s2_q    <= s1_q;
      rb1_q   <= pad_in_i;
      rb2_q   <= rb1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      pd_q    <= pd_d;
      fcnt_q  <= fcnt_d;
      fault_q <= fault_d;
    end
  end

  assign pd_o    = pd_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/mioc_inv_od_array.sv
// N-channel open-drain inverter array; each channel is independent and
// only drives its pad low or releases it for the external pull-up.
module mioc_inv_od_array #(
  parameter int NCH       = 4,
  parameter int FILT_CYC  = 4,
  parameter int FAULT_CYC = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in,
  input  logic [NCH-1:0] oe,
  input  logic           inv_mode,
  output wire  [NCH-1:0] z,
  input  logic [NCH-1:0] pad_in,
  output logic [NCH-1:0] pd,
  output logic [NCH-1:0] fault,
  input  logic [NCH-1:0] fault_clr
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    mioc_od_chan #(
      .FILT_CYC  (FILT_CYC),
      .FAULT_CYC (FAULT_CYC)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .in_i        (in[g]),
      .oe_i        (oe[g]),
      .inv_mode_i  (inv_mode),
      .pad_in_i    (pad_in[g]),
      .fault_clr_i (fault_clr[g]),
      .pd_o        (pd[g]),
      .fault_o     (fault[g])
    );

    // Never drive high: low or released.
    assign z[g] = pd[g] ? 1'b0 : 1'bz;
  end

endmodule

// File: tb/tb_mioc_inv_od_array.sv
// Directed bench for mioc_inv_od_array with a window-based reference
// model and an external pull-up on the pads.
module tb_mioc_inv_od_array;

  localparam int NCH = 4;
  localparam int FC  = 4;
  localparam int KC  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] in_v, oe_v, clr_v, frc_v;
  logic           inv_v;
  wire  [NCH-1:0] zb;
  logic [NCH-1:0] pad_v;
  logic [NCH-1:0] pd_w, fault_w;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCH; g++) begin : g_pu
    pullup (zb[g]);
  end

  // Resolved pad level, optionally held low by an external driver.
  assign pad_v = zb & ~frc_v;

  mioc_inv_od_array #(
    .NCH       (NCH),
    .FILT_CYC  (FC),
    .FAULT_CYC (KC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_v),
    .oe        (oe_v),
    .inv_mode  (inv_v),
    .z         (zb),
    .pad_in    (pad_v),
    .pd        (pd_w),
    .fault     (fault_w),
    .fault_clr (clr_v)
  );

  task automatic chk(string nm, logic [NCH-1:0] act, logic [NCH-1:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: filt flips once the last FC synchronised samples all
  // disagree with it; fault sets on the KC-th consecutive contention edge.
  bit m_s1[NCH], m_s2[NCH], m_rb1[NCH], m_rb2[NCH];
  bit m_filt[NCH], m_pd[NCH], m_fault[NCH];
  bit m_win[NCH][FC];
  int m_run[NCH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_rb1[i] = 0; m_rb2[i] = 0;
        m_filt[i] = 0; m_pd[i] = 0; m_fault[i] = 0; m_run[i] = 0;
        for (int j = 0; j < FC; j++) m_win[i][j] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        bit c, all_diff;
        c = oe_v[i] && !m_pd[i] && !m_rb2[i];
        if (clr_v[i]) begin
          m_fault[i] = 0;
          m_run[i] = 0;
        end else if (c) begin
          m_run[i]++;
          if (m_run[i] >= KC) m_fault[i] = 1;
        end else begin
          m_run[i] = 0;
        end
        m_pd[i] = oe_v[i] && (inv_v ? m_filt[i] : !m_filt[i]);
        for (int j = 0; j < FC - 1; j++) m_win[i][j] = m_win[i][j+1];
        m_win[i][FC-1] = m_s2[i];
        all_diff = 1;
        for (int j = 0; j < FC; j++)
          if (m_win[i][j] == m_filt[i]) all_diff = 0;
        if (all_diff) m_filt[i] = !m_filt[i];
        m_rb2[i] = m_rb1[i]; m_rb1[i] = pad_v[i];
        m_s2[i] = m_s1[i];   m_s1[i] = in_v[i];
      end
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] epd, eft;
    for (int i = 0; i < NCH; i++) begin
      epd[i] = m_pd[i];
      eft[i] = m_fault[i];
    end
    chk("model_pd", pd_w, epd);
    chk("model_fault", fault_w, eft);
    chk("model_z", zb, ~epd);
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_v = '0; oe_v = '0; inv_v = 1'b1;
    clr_v = '0; frc_v = '0;
    #1;
    chk("rst_pd", pd_w, 4'b0000);
    chk("rst_fault", fault_w, 4'b0000);
    chk("rst_z", zb, 4'b1111);

    // Reset hold, then async reset mid-run with all pads pulled down.
    oe_v = 4'b1111; inv_v = 1'b0;
    edges(2);
    chk("hold_pd", pd_w, 4'b0000);
    rst = 1'b0;
    edges(1);
    chk("run_pd", pd_w, 4'b1111);
    chk("run_z", zb, 4'b0000);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_pd", pd_w, 4'b0000);
    chk("async_fault", fault_w, 4'b0000);
    chk("async_z", zb, 4'b1111);
    edges(1);
    rst = 1'b0;
    edges(4);

    // Latency on channel 0.
    oe_v = 4'b0001; inv_v = 1'b1; in_v = '0;
    do_reset();
    edges(2);
    in_v[0] = 1'b1;
    edges(6);
    chk("lat_e6_pd", pd_w, 4'b0000);
    edges(1);
    chk("lat_e7_pd", pd_w, 4'b0001);
    chk("lat_e7_z", zb, 4'b1110);

    // Glitch reject and accept on channel 1.
    oe_v = 4'b0010; in_v = '0;
    do_reset();
    edges(1);
    in_v[1] = 1'b1;
    edges(3);
    in_v[1] = 1'b0;
    edges(12);
    chk("glitch3_pd", pd_w, 4'b0000);
    in_v[1] = 1'b1;
    edges(4);
    in_v[1] = 1'b0;
    edges(3);
    chk("pulse4_e7_pd", pd_w, 4'b0010);
    edges(3);
    chk("pulse4_e10_pd", pd_w, 4'b0010);
    edges(1);
    chk("pulse4_e11_pd", pd_w, 4'b0000);

    // Polarity switch.
    oe_v = 4'b1111; inv_v = 1'b1; in_v = '0;
    do_reset();
    edges(3);
    chk("pol_inv_pd", pd_w, 4'b0000);
    inv_v = 1'b0;
    edges(1);
    chk("pol_buf_pd", pd_w, 4'b1111);

    // Contention on channel 2.
    inv_v = 1'b1; oe_v = 4'b0100; in_v = '0;
    do_reset();
    edges(3);
    frc_v[2] = 1'b1;
    edges(9);
    chk("cont_e9_fault", fault_w, 4'b0000);
    edges(1);
    chk("cont_e10_fault", fault_w, 4'b0100);
    frc_v[2] = 1'b0;
    edges(5);
    chk("sticky_fault", fault_w, 4'b0100);
    clr_v[2] = 1'b1;
    edges(1);
    clr_v[2] = 1'b0;
    chk("clr_fault", fault_w, 4'b0000);
    edges(4);
    frc_v[2] = 1'b1;
    edges(9);
    clr_v[2] = 1'b1;
    edges(1);
    chk("clr_prio_fault", fault_w, 4'b0000);
    clr_v[2] = 1'b0;
    frc_v[2] = 1'b0;
    edges(4);
    chk("clr_prio_after", fault_w, 4'b0000);

    // Self-release must not look like contention on channel 3.
    oe_v = 4'b1000; inv_v = 1'b1; in_v = '0;
    do_reset();
    edges(1);
    in_v[3] = 1'b1;
    edges(10);
    chk("self_on_pd", pd_w, 4'b1000);
    in_v[3] = 1'b0;
    edges(20);
    chk("self_off_pd", pd_w, 4'b0000);
    chk("self_off_fault", fault_w, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
